// File: rtl/squarer_arbiter.sv
// -----------------------------------------------------------------------------
// squarer_arbiter
//
// Shares one external signed 40x40 squarer (80-bit result) between N
// requesters. A round-robin arbiter grants one requester per cycle through a
// valid/ready handshake. The accepted operand is registered onto sq_dataa.
// A tag {valid, id} travels alongside the operand through a shift register
// that matches the squarer latency, so the returning square can be captured
// and labelled with its requester index.
//
// Parameters
//   N    number of requesters (2..16)
//   LAT  pipeline latency of the attached squarer in cycles (0 = combinational)
//   IDW  width of the requester index, must equal ceil(log2(N))
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   enable     1 = new grants allowed; in-flight ops always complete
//   req_valid  per-requester request valid                     [N]
//   req_data   per-requester signed operand, slot i at [40*i+:40]
//   req_ready  one-hot grant (combinational)                  [N]
//   sq_dataa   registered operand driven to the squarer       [40]
//   sq_result  square returned by the squarer                 [80]
//   res_valid  one-cycle strobe per accepted op
//   res_id     requester index of the result                  [IDW]
//   res_data   registered signed square                       [80]
//   busy       1 while any accepted op has not produced res_valid
// -----------------------------------------------------------------------------
module squarer_arbiter #(
  parameter int N   = 4,
  parameter int LAT = 0,
  parameter int IDW = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [N-1:0]     req_valid,
  input  logic [N*40-1:0]  req_data,
  output logic [N-1:0]     req_ready,
  output logic [39:0]      sq_dataa,
  input  logic [79:0]      sq_result,
  output logic             res_valid,
  output logic [IDW-1:0]   res_id,
  output logic [79:0]      res_data,
  output logic             busy
);

  localparam int DATA_W = 40;
  localparam int RES_W  = 2 * DATA_W;

  // Index arithmetic modulo N. N need not be a power of two, so the wrap is
  // done explicitly instead of relying on IDW-bit overflow.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                              input int             off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return s[IDW-1:0];
  endfunction

  // Round-robin pointer: highest-priority index for the next arbitration.
  logic [IDW-1:0] ptr_q;

  // Grant decode
  logic [N-1:0]               grant;
  logic [IDW-1:0]             gnt_idx;
  logic [IDW-1:0]             scan_idx;
  logic                       found;
  logic                       accept;
  logic signed [DATA_W-1:0]   gnt_data;

  // Issue stage
  logic signed [DATA_W-1:0]   dataa_p0;

  // Tag pipeline, depth LAT+1, aligned with the squarer pipeline
  logic [LAT:0]               tag_vld_p;
  logic [IDW-1:0]             tag_id_p [LAT:0];

  // Result stage
  logic                       vld_p1;
  logic [IDW-1:0]             id_p1;
  logic signed [RES_W-1:0]    data_p1;

  // Scan N slots starting at the pointer; the first valid one wins. Grants
  // depend on req_valid in the same cycle, so requesters must not loop
  // req_valid back from req_ready.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    scan_idx = '0;
    found    = 1'b0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        scan_idx = wrap_idx(ptr_q, k);
        if (!found && req_valid[scan_idx]) begin
          found          = 1'b1;
          grant[scan_idx] = 1'b1;
          gnt_idx        = scan_idx;
        end
      end
    end
  end

  // A grant is only raised on a valid slot, so any grant bit is a handshake.
  assign accept   = |grant;
  assign gnt_data = $signed(req_data[gnt_idx*DATA_W +: DATA_W]);

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= wrap_idx(gnt_idx, 1);
    end
  end

  // ---- stage p0: operand issue to the squarer ----
  // The operand holds between accepts so the squarer input stays quiet.
  always_ff @(posedge clock) begin
    if (reset) begin
      dataa_p0 <= '0;
    end else if (accept) begin
      dataa_p0 <= gnt_data;
    end
  end

  // ---- tag pipeline: p0 .. pLAT, tracks each op through the squarer ----
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_vld_p <= '0;
      for (int i = 0; i <= LAT; i++) begin
        tag_id_p[i] <= '0;
      end
    end else begin
      tag_vld_p[0] <= accept;
      tag_id_p[0]  <= gnt_idx;
      for (int i = 1; i <= LAT; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_id_p[i]  <= tag_id_p[i-1];
      end
    end
  end

  // ---- stage p1: result capture when a valid tag leaves the pipeline ----
  // id/data hold between results so the bus stays stable for the consumer.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      id_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= tag_vld_p[LAT];
      if (tag_vld_p[LAT]) begin
        id_p1   <= tag_id_p[LAT];
        data_p1 <= $signed(sq_result);
      end
    end
  end

  assign req_ready = grant;
  assign sq_dataa  = dataa_p0;
  assign res_valid = vld_p1;
  assign res_id    = id_p1;
  assign res_data  = data_p1;
  assign busy      = |tag_vld_p;

endmodule

// File: tb/tb_squarer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_squarer_arbiter
//
// Two instances of squarer_arbiter share one clock: index 0 uses LAT=0 with a
// combinational squarer, index 1 uses LAT=2 with a two-register squarer. A
// queue-based model predicts grants and results for both, and directed
// sequences carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_squarer_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst  [2];
  logic             en   [2];
  logic [N-1:0]     rv   [2];
  logic [N*40-1:0]  rd   [2];
  logic [N-1:0]     rr   [2];
  logic [39:0]      sqa  [2];
  logic [79:0]      sqr  [2];
  logic             resv [2];
  logic [IDW-1:0]   rid  [2];
  logic [79:0]      rdat [2];
  logic             bsy  [2];

  logic [79:0] sq2_p1, sq2_p2;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [79:0] sq80(input logic [39:0] a);
    logic signed [79:0] x;
    x = $signed({{40{a[39]}}, a});
    return x * x;
  endfunction

  squarer_arbiter #(.N(N), .LAT(0), .IDW(IDW)) dut_l0 (
    .clock(clk), .reset(rst[0]), .enable(en[0]),
    .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr[0]),
    .sq_dataa(sqa[0]), .sq_result(sqr[0]),
    .res_valid(resv[0]), .res_id(rid[0]), .res_data(rdat[0]), .busy(bsy[0])
  );

  squarer_arbiter #(.N(N), .LAT(2), .IDW(IDW)) dut_l2 (
    .clock(clk), .reset(rst[1]), .enable(en[1]),
    .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr[1]),
    .sq_dataa(sqa[1]), .sq_result(sqr[1]),
    .res_valid(resv[1]), .res_id(rid[1]), .res_data(rdat[1]), .busy(bsy[1])
  );

  // External squarers
  assign sqr[0] = sq80(sqa[0]);
  always @(posedge clk) begin
    sq2_p1 <= sq80(sqa[1]);
    sq2_p2 <= sq2_p1;
  end
  assign sqr[1] = sq2_p2;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: each cycle (observed at the falling edge) the grant is
  // the first valid requester at or after the pointer, wrapping. A grant in
  // cycle c yields a result visible in cycle c+LAT+2 (LAT+1 edges after the
  // handshake edge). busy is high while any accepted op is still owed.
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    int          id;
    logic [39:0] op;
  } op_t;

  op_t         mq    [2][$];
  int          m_ptr [2] = '{0, 0};
  int          m_cyc [2] = '{0, 0};
  bit          m_arm [2] = '{1'b0, 1'b0};
  logic [1:0]  m_id  [2] = '{2'd0, 2'd0};
  logic [79:0] m_dat [2] = '{80'd0, 80'd0};
  logic [39:0] m_sqa [2] = '{40'd0, 40'd0};

  function automatic int exp_grant(input logic [N-1:0] v, input logic e, input int p);
    if (!e) return -1;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int         g;
      bit         ev;
      logic [3:0] eg;
      op_t        e;
      ev = 1'b0;
      if (mq[i].size() != 0 && mq[i][0].due == m_cyc[i]) begin
        e       = mq[i].pop_front();
        ev      = 1'b1;
        m_id[i] = 2'(e.id);
        m_dat[i] = sq80(e.op);
      end
      g  = exp_grant(rv[i], en[i], m_ptr[i]);
      eg = (g >= 0) ? 4'(1 << g) : 4'd0;
      if (m_arm[i]) begin
        chk($sformatf("model%0d.req_ready", i), 80'(rr[i]),   80'(eg));
        chk($sformatf("model%0d.res_valid", i), 80'(resv[i]), 80'(ev));
        chk($sformatf("model%0d.res_id", i),    80'(rid[i]),  80'(m_id[i]));
        chk($sformatf("model%0d.res_data", i),  rdat[i],      m_dat[i]);
        chk($sformatf("model%0d.busy", i),      80'(bsy[i]),  80'(mq[i].size() != 0));
        chk($sformatf("model%0d.sq_dataa", i),  80'(sqa[i]),  80'(m_sqa[i]));
      end
      if (rst[i]) begin
        mq[i].delete();
        m_ptr[i] = 0;
        m_sqa[i] = '0;
        m_id[i]  = '0;
        m_dat[i] = '0;
        m_arm[i] = 1'b1;
      end else if (g >= 0) begin
        mq[i].push_back('{due: m_cyc[i] + ((i == 0) ? 0 : 2) + 2, id: g, op: rd[i][g*40 +: 40]});
        m_ptr[i] = (g + 1) % N;
        m_sqa[i] = rd[i][g*40 +: 40];
      end
      m_cyc[i]++;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [39:0] b_op  [3];
    logic [79:0] b_exp [3];
    logic [3:0]  onehot;
    int          v;

    rst[0] = 1'b1; rst[1] = 1'b1;
    en[0]  = 1'b1; en[1]  = 1'b1;
    rv[0]  = '0;   rv[1]  = '0;
    rd[0]  = '0;   rd[1]  = '0;
    repeat (2) next_cycle();
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Idle after reset (LAT=0)
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle.req_ready", 80'(rr[0]),   80'd0);
      chk("idle.res_valid", 80'(resv[0]), 80'd0);
      chk("idle.busy",      80'(bsy[0]),  80'd0);
      next_cycle();
    end

    // Single op from requester 2: 3 -> 9, then -5 -> 25 (LAT=0)
    rd[0][80 +: 40] = 40'd3;
    rv[0] = 4'b0100;
    @(negedge clk);
    chk("single.grant", 80'(rr[0]), 80'h4);
    next_cycle();
    rv[0] = 4'b0000;
    @(negedge clk);
    chk("single.busy",        80'(bsy[0]),  80'd1);
    chk("single.early_valid", 80'(resv[0]), 80'd0);
    next_cycle();
    @(negedge clk);
    chk("single.res_valid", 80'(resv[0]), 80'd1);
    chk("single.res_id",    80'(rid[0]),  80'd2);
    chk("single.res_data",  rdat[0],      80'd9);
    next_cycle();
    rd[0][80 +: 40] = 40'hFF_FFFF_FFFB;
    rv[0] = 4'b0100;
    @(negedge clk);
    chk("neg.grant", 80'(rr[0]), 80'h4);
    next_cycle();
    rv[0] = 4'b0000;
    next_cycle();
    @(negedge clk);
    chk("neg.res_id",   80'(rid[0]), 80'd2);
    chk("neg.res_data", rdat[0],     80'd25);
    next_cycle();

    // Boundary operands back to back from requester 0 (LAT=0)
    b_op[0] = 40'h80_0000_0000;  b_exp[0] = 80'h4000_0000_0000_0000_0000;
    b_op[1] = 40'h7F_FFFF_FFFF;  b_exp[1] = 80'h3FFF_FFFF_FF00_0000_0001;
    b_op[2] = 40'h00_0000_0000;  b_exp[2] = 80'h0;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        rv[0] = 4'b0001;
        rd[0][39:0] = b_op[k];
      end else begin
        rv[0] = 4'b0000;
      end
      @(negedge clk);
      if (k < 3) chk("bound.grant", 80'(rr[0]), 80'h1);
      if (k >= 2) begin
        chk("bound.res_valid", 80'(resv[0]), 80'd1);
        chk("bound.res_data",  rdat[0],      b_exp[k-2]);
      end
      next_cycle();
    end

    // Round-robin fairness with all four requesters (LAT=2)
    rd[1] = {40'd4, 40'd3, 40'd2, 40'd1};
    for (int k = 0; k < 13; k++) begin
      rv[1] = (k < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (k < 8) begin
        onehot = 4'b0001 << (k % 4);
        chk("rr.grant", 80'(rr[1]), 80'(onehot));
      end
      if (k >= 4 && k < 12) begin
        v = (k - 4) % 4 + 1;
        chk("rr.res_valid", 80'(resv[1]), 80'd1);
        chk("rr.res_id",    80'(rid[1]),  80'(v - 1));
        chk("rr.res_data",  rdat[1],      80'(v * v));
      end
      chk("rr.busy", 80'(bsy[1]), 80'(k >= 1 && k <= 10));
      next_cycle();
    end

    // enable dropped one cycle after a grant (LAT=2)
    for (int k = 0; k < 6; k++) begin
      en[1] = (k == 0 || k == 5);
      rv[1] = (k == 0) ? 4'b0010 : 4'b1111;
      @(negedge clk);
      if (k == 0) chk("en.grant", 80'(rr[1]), 80'h2);
      if (k >= 1 && k <= 4) chk("en.no_grant", 80'(rr[1]), 80'h0);
      if (k == 4) begin
        chk("en.res_valid", 80'(resv[1]), 80'd1);
        chk("en.res_id",    80'(rid[1]),  80'd1);
        chk("en.res_data",  rdat[1],      80'd4);
      end
      if (k == 5) chk("en.ptr_held", 80'(rr[1]), 80'h4);
      next_cycle();
    end
    rv[1] = 4'b0000;
    en[1] = 1'b1;
    repeat (6) next_cycle();

    // Reset while ops from requesters 3 and 1 are in flight (LAT=2)
    for (int k = 0; k < 10; k++) begin
      rv[1]  = (k == 0) ? 4'b1000 : (k == 1) ? 4'b0010 : (k == 9) ? 4'b1111 : 4'b0000;
      rst[1] = (k == 2);
      @(negedge clk);
      if (k == 0) chk("rst.grant3", 80'(rr[1]), 80'h8);
      if (k == 1) chk("rst.grant1", 80'(rr[1]), 80'h2);
      if (k == 2) chk("rst.busy_before", 80'(bsy[1]), 80'd1);
      if (k >= 3 && k <= 8) begin
        chk("rst.no_result", 80'(resv[1]), 80'd0);
        chk("rst.busy_after", 80'(bsy[1]), 80'd0);
      end
      if (k == 3) chk("rst.sq_dataa", 80'(sqa[1]), 80'd0);
      if (k == 9) chk("rst.ptr_zero", 80'(rr[1]), 80'h1);
      next_cycle();
    end
    rv[1] = 4'b0000;
    repeat (6) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
